// File: rtl/boot_pkg.sv
// Shared definitions for the multiboot front end and the ICAP sequencer:
// flash image map, SPI read opcode and the front-end state encoding.
package boot_pkg;

    localparam logic [23:0] IMG_LOADER  = 24'h000000;
    localparam logic [23:0] IMG_MODELB  = 24'h054000;
    localparam logic [23:0] IMG_MASTER  = 24'h0A8000;
    localparam logic [7:0]  SPI_READ_OP = 8'h03;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_AUTO,
        ST_IDLE,
        ST_TIMING,
        ST_REQ,
        ST_RELEASE
    } boot_state_e;

    // GENERAL_2 carries the SPI read opcode and the upper address byte.
    function automatic logic [15:0] gen2_word(input logic [23:0] img_addr);
        return {SPI_READ_OP, img_addr[23:16]};
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a saturating debouncer: the output follows
// the input only after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             out_q;
    logic             out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample equal to the current output restarts the run count.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (sync_q != out_q) begin
            if (cnt_q >= CNT_LAST) begin
                out_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/boot_image_select.sv
// Multiboot front end: conditions DIP switches and reboot button, chooses the
// flash image and hands its address to the ICAP sequencer over req/ack.
module boot_image_select
    import boot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES     = 16777216,
    parameter int unsigned STARTUP_CYCLES  = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  dip,
    input  logic        btn,
    output logic        req,
    input  logic        ack,
    output logic [23:0] addr,
    output logic [15:0] gen1,
    output logic [15:0] gen2,
    output logic        led
);

    localparam int unsigned      SW         = $clog2(STARTUP_CYCLES + 1);
    localparam int unsigned      HW         = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0]    START_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_MAX   = HW'(HOLD_CYCLES);

    logic [3:0]  dip_db;
    logic        btn_db;
    logic        unused_dip_db;

    boot_state_e state_q, state_d;
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic        btn_prev_q, btn_prev_d;
    logic        req_q, req_d;
    logic        led_q, led_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] gen1_q, gen1_d;
    logic [15:0] gen2_q, gen2_d;
    logic        load_en;
    logic [23:0] load_val;
    logic [23:0] sel_img;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clock (clock),
        .reset (reset),
        .din   (btn),
        .dout  (btn_db)
    );

    for (genvar i = 0; i < 4; i++) begin : g_dip_db
        debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dip_db (
            .clock (clock),
            .reset (reset),
            .din   (dip[i]),
            .dout  (dip_db[i])
        );
    end

    // dip[1] and dip[3] are reserved switches with no function yet.
    assign unused_dip_db = dip_db[1] ^ dip_db[3];

    assign sel_img = dip_db[2] ? IMG_MASTER : IMG_MODELB;

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        btn_prev_d  = btn_db;
        addr_d      = addr_q;
        gen1_d      = gen1_q;
        gen2_d      = gen2_q;
        load_en     = 1'b0;
        load_val    = sel_img;

        case (state_q)
            ST_STARTUP: begin
                if (start_cnt_q >= START_LAST) begin
                    state_d = dip_db[0] ? ST_AUTO : ST_IDLE;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            ST_AUTO: begin
                load_en = 1'b1;
                state_d = ST_REQ;
            end
            ST_IDLE: begin
                // Only a fresh edge counts; a press still held on entry is ignored.
                if (btn_db && !btn_prev_q) begin
                    hold_cnt_d = '0;
                    state_d    = ST_TIMING;
                end
            end
            ST_TIMING: begin
                // Saturation wins over a simultaneous release.
                if (hold_cnt_q >= HOLD_MAX) begin
                    load_val = IMG_LOADER;
                    load_en  = 1'b1;
                    state_d  = ST_REQ;
                end else if (!btn_db) begin
                    load_en = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack && !btn_db) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_STARTUP;
        endcase

        if (load_en) begin
            addr_d = load_val;
            gen1_d = load_val[15:0];
            gen2_d = gen2_word(load_val);
        end

        req_d = (state_d == ST_REQ);
        led_d = (state_d == ST_TIMING) || (state_d == ST_REQ) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_STARTUP;
            start_cnt_q <= '0;
            hold_cnt_q  <= '0;
            btn_prev_q  <= 1'b0;
            req_q       <= 1'b0;
            led_q       <= 1'b0;
            addr_q      <= IMG_LOADER;
            gen1_q      <= 16'h0000;
            gen2_q      <= {SPI_READ_OP, 8'h00};
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            btn_prev_q  <= btn_prev_d;
            req_q       <= req_d;
            led_q       <= led_d;
            addr_q      <= addr_d;
            gen1_q      <= gen1_d;
            gen2_q      <= gen2_d;
        end
    end

    assign req  = req_q;
    assign led  = led_q;
    assign addr = addr_q;
    assign gen1 = gen1_q;
    assign gen2 = gen2_q;

endmodule

// File: tb/tb_boot_image_select.sv
// Randomised scoreboard bench for boot_image_select with small debounce, hold
// and startup counts so every boot path is exercised quickly.
module tb_boot_image_select;

    localparam int DEB   = 4;
    localparam int HOLD  = 32;
    localparam int START = 8;

    localparam logic [23:0] A_LOADER = 24'h000000;
    localparam logic [23:0] A_MODELB = 24'h054000;
    localparam logic [23:0] A_MASTER = 24'h0A8000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dip   = 4'b0000;
    logic        btn   = 1'b0;
    logic        ack   = 1'b0;
    logic        req;
    logic [23:0] addr;
    logic [15:0] gen1;
    logic [15:0] gen2;
    logic        led;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rises    = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    logic [23:0] held_addr = '0;
    logic        req_prev  = 1'b0;

    boot_image_select #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STARTUP_CYCLES  (START)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dip   (dip),
        .btn   (btn),
        .req   (req),
        .ack   (ack),
        .addr  (addr),
        .gen1  (gen1),
        .gen2  (gen2),
        .led   (led)
    );

    always #5 clock = ~clock;

    // Reference: a long press always boots the loader, otherwise dip[2] picks the image.
    function automatic logic [23:0] image_for(input bit master_sel, input bit long_p);
        if (long_p) return A_LOADER;
        return master_sel ? A_MASTER : A_MODELB;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each rising req is matched against the oldest expected image.
    always @(negedge clock) begin
        if (req && !req_prev) begin
            rises++;
            held_addr = addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: req rose with addr 0x%0h, no request expected", addr);
            end else begin
                mon_exp = exp_q.pop_front();
                check("req_addr", addr, mon_exp);
                check("req_gen1", gen1, mon_exp[15:0]);
                check("req_gen2", gen2, {8'h03, mon_exp[23:16]});
            end
        end else if (req && req_prev) begin
            check("addr_stable", addr, held_addr);
        end
        req_prev = req;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_req(input int max, output int cyc);
        cyc = 0;
        while (!req && cyc < max) begin
            @(negedge clock);
            cyc++;
        end
        n_checks++;
        if (!req) begin
            n_fail++;
            $display("FAIL req_timeout: req=%0b after %0d cycles, expected 1", req, cyc);
        end
    endtask

    task automatic wait_led_low(input int max);
        int cyc;
        cyc = 0;
        while (led && cyc < max) begin
            @(negedge clock);
            cyc++;
        end
        check("led_back_to_idle", led, 0);
    endtask

    task automatic handshake();
        ack = 1'b1;
        @(negedge clock);
        check("req_drop_after_ack", req, 0);
        ack = 1'b0;
    endtask

    task automatic do_press(input bit master_sel, input bit long_p, input int d);
        int r0;
        int cyc;
        int el;
        dip = {1'b0, master_sel, 2'b00};
        tick(10);
        exp_q.push_back(image_for(master_sel, long_p));
        r0  = rises;
        btn = 1'b1;
        if (long_p) begin
            wait_req(d, cyc);
            handshake();
            el = cyc + 1;
            if (el < d) tick(d - el);
            check("led_release_held", led, 1);
        end else begin
            tick(d);
            check("led_timing", led, 1);
            check("no_req_before_release", rises, r0);
        end
        btn = 1'b0;
        if (!long_p) begin
            wait_req(30, cyc);
            handshake();
        end
        wait_led_low(40);
        tick(20);
        check("one_req_per_press", rises, r0 + 1);
    endtask

    initial begin
        int cyc;
        int bad;
        int r0;
        bit sel;
        bit lp;
        int d;

        // Reset state and auto-boot of the master image.
        reset = 1'b1;
        dip   = 4'b0101;
        tick(3);
        check("rst_req", req, 0);
        check("rst_led", led, 0);
        check("rst_addr", addr, 24'h000000);
        check("rst_gen1", gen1, 16'h0000);
        check("rst_gen2", gen2, 16'h0300);
        exp_q.push_back(A_MASTER);
        reset = 1'b0;
        wait_req(40, cyc);
        check("startup_delay_in_range", (cyc >= START) && (cyc <= START + 4), 1);

        // req must hold without ack while the dips move underneath it.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 7 == 0) dip[2] = ~dip[2];
            @(negedge clock);
            if (!req) bad++;
        end
        check("req_held_without_ack", bad, 0);
        ack = 1'b1;
        @(negedge clock);
        check("req_drop_on_ack", req, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (req || !led) bad++;
        end
        check("release_waits_ack_low", bad, 0);
        ack = 1'b0;
        wait_led_low(20);
        dip = 4'b0000;

        // Random short and long presses.
        for (int k = 0; k < 6; k++) begin
            sel = 1'($urandom_range(0, 1));
            lp  = (k < 2) ? k[0] : 1'($urandom_range(0, 1));
            d   = lp ? int'($urandom_range(48, 70)) : int'($urandom_range(10, 25));
            do_press(sel, lp, d);
        end

        // Bouncing button must never be accepted.
        r0  = rises;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 2) % 2) == 0;
            @(negedge clock);
            if (led) bad++;
        end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (led) bad++;
        end
        check("bounce_led_low", bad, 0);
        check("bounce_no_req", rises, r0);

        // Reset while a request is outstanding.
        dip = 4'b0000;
        tick(10);
        exp_q.push_back(A_MODELB);
        btn = 1'b1;
        tick(12);
        btn = 1'b0;
        wait_req(30, cyc);
        tick(2);
        reset = 1'b1;
        dip   = 4'b0001;
        @(negedge clock);
        check("midreq_rst_req", req, 0);
        check("midreq_rst_addr", addr, 24'h000000);
        check("midreq_rst_gen1", gen1, 16'h0000);
        check("midreq_rst_gen2", gen2, 16'h0300);
        check("midreq_rst_led", led, 0);
        tick(1);
        exp_q.push_back(A_MODELB);
        reset = 1'b0;
        wait_req(40, cyc);
        check("startup_reapplied", (cyc >= START) && (cyc <= START + 4), 1);
        handshake();
        wait_led_low(20);
        tick(5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
